// File: rtl/traffic_light_multi.sv
// rtl/traffic_light_multi.sv - N-way round-robin traffic-light controller with pass-request shortening and flash mode
module traffic_light_multi #(
  parameter int N_WAY     = 2,
  parameter int CNT_W     = 8,
  parameter int T_GREEN   = 60,
  parameter int T_YELLOW  = 5,
  parameter int T_RED_CLR = 2,
  parameter int T_PASS    = 10,
  parameter int T_FLASH   = 4,
  parameter int IDX_W     = $clog2(N_WAY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flash_mode,
  input  logic [N_WAY-1:0] pass_request,
  output logic [N_WAY-1:0] red,
  output logic [N_WAY-1:0] yellow,
  output logic [N_WAY-1:0] green,
  output logic [IDX_W-1:0] active_way,
  output logic [CNT_W-1:0] clock,
  output logic             phase_done
);

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_FLASH  = 2'd3
  } state_t;

  // Flash counter spans a full lit+dark blink period, so it needs one bit more than the phase counter.
  localparam int FC_W = CNT_W + 1;

  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] LD_RED    = CNT_W'(T_RED_CLR);
  localparam logic [CNT_W-1:0] LD_PASS   = CNT_W'(T_PASS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_WAY  = IDX_W'(N_WAY - 1);
  localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(2 * T_FLASH - 1);
  localparam logic [FC_W-1:0]  FC_LIT    = FC_W'(T_FLASH);
  localparam logic [N_WAY-1:0] ALL_ON    = '1;
  localparam logic [N_WAY-1:0] ONE_HOT0  = N_WAY'(1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] clock_d;
  logic [IDX_W-1:0] way_d;
  logic [IDX_W-1:0] way_inc;
  logic [FC_W-1:0]  flash_cnt_q;
  logic [FC_W-1:0]  flash_cnt_d;
  logic [N_WAY-1:0] req_pend_q;
  logic [N_WAY-1:0] req_pend_d;
  logic [N_WAY-1:0] req_seen;
  logic [N_WAY-1:0] way_mask;
  logic [N_WAY-1:0] way_mask_d;
  logic [N_WAY-1:0] red_d;
  logic [N_WAY-1:0] yellow_d;
  logic [N_WAY-1:0] green_d;
  logic             last_cycle;
  logic             shorten;
  logic             entering_green;

  // Requests arriving this cycle count immediately, so a pulse shortens green on the very next edge.
  assign req_seen   = req_pend_q | pass_request;
  assign way_mask   = ONE_HOT0 << active_way;
  assign way_inc    = (active_way == LAST_WAY) ? '0 : active_way + IDX_W'(1);
  assign last_cycle = (clock <= CNT_ONE);
  assign shorten    = (state_q == ST_GREEN) && (|(req_seen & ~way_mask)) && (clock > LD_PASS);

  // State register: FSM state, countdown, active way, lamps, pending requests and blink counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ALLRED;
      clock       <= LD_RED;
      active_way  <= LAST_WAY;
      flash_cnt_q <= '0;
      req_pend_q  <= '0;
      red         <= ALL_ON;
      yellow      <= '0;
      green       <= '0;
    end else begin
      state_q     <= state_d;
      clock       <= clock_d;
      active_way  <= way_d;
      flash_cnt_q <= flash_cnt_d;
      req_pend_q  <= req_pend_d;
      red         <= red_d;
      yellow      <= yellow_d;
      green       <= green_d;
    end
  end

  // Next-state logic: flash overrides everything, leaving flash goes to clearance, en=0 freezes.
  always_comb begin
    state_d     = state_q;
    clock_d     = clock;
    way_d       = active_way;
    flash_cnt_d = flash_cnt_q;
    if (flash_mode) begin
      state_d = ST_FLASH;
      clock_d = '0;
      if (state_q == ST_FLASH) begin
        flash_cnt_d = (flash_cnt_q == FC_LAST) ? '0 : flash_cnt_q + FC_W'(1);
      end else begin
        flash_cnt_d = '0;
      end
    end else if (state_q == ST_FLASH) begin
      state_d     = ST_ALLRED;
      clock_d     = LD_RED;
      flash_cnt_d = '0;
    end else if (en) begin
      if (last_cycle) begin
        case (state_q)
          ST_ALLRED: begin
            state_d = ST_GREEN;
            way_d   = way_inc;
            clock_d = LD_GREEN;
          end
          ST_GREEN: begin
            state_d = ST_YELLOW;
            clock_d = LD_YELLOW;
          end
          default: begin
            state_d = ST_ALLRED;
            clock_d = LD_RED;
          end
        endcase
      end else if (shorten) begin
        clock_d = LD_PASS;
      end else begin
        clock_d = clock - CNT_ONE;
      end
    end
  end

  // Pending requests latch in every mode; the way that just gained green drops its own request.
  always_comb begin
    entering_green = (state_d == ST_GREEN) && (state_q != ST_GREEN);
    way_mask_d     = ONE_HOT0 << way_d;
    req_pend_d     = req_seen;
    if (entering_green) begin
      req_pend_d = req_seen & ~way_mask_d;
    end
  end

  // Output logic: lamp pattern for the state being entered, plus the end-of-phase pulse.
  always_comb begin
    red_d    = '0;
    yellow_d = '0;
    green_d  = '0;
    case (state_d)
      ST_GREEN: begin
        green_d = way_mask_d;
        red_d   = ~way_mask_d;
      end
      ST_YELLOW: begin
        yellow_d = way_mask_d;
        red_d    = ~way_mask_d;
      end
      ST_FLASH: begin
        yellow_d = (flash_cnt_d < FC_LIT) ? ALL_ON : '0;
      end
      default: begin
        red_d = ALL_ON;
      end
    endcase
    phase_done = !rst && !flash_mode && en && (state_q != ST_FLASH) && last_cycle;
  end

endmodule

// File: tb/tb_traffic_light_multi.sv
// tb/tb_traffic_light_multi.sv - self-checking bench for traffic_light_multi
module tb_traffic_light_multi;

  localparam int N  = 2;
  localparam int CW = 8;
  localparam int TG = 60;
  localparam int TY = 5;
  localparam int TR = 2;
  localparam int TP = 10;
  localparam int TF = 4;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b1;
  logic          flash_mode = 1'b0;
  logic [N-1:0]  pass_request = '0;
  logic [N-1:0]  red;
  logic [N-1:0]  yellow;
  logic [N-1:0]  green;
  logic [IW-1:0] active_way;
  logic [CW-1:0] clock;
  logic          phase_done;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_light_multi #(
    .N_WAY(N), .CNT_W(CW), .T_GREEN(TG), .T_YELLOW(TY),
    .T_RED_CLR(TR), .T_PASS(TP), .T_FLASH(TF)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .flash_mode(flash_mode),
    .pass_request(pass_request), .red(red), .yellow(yellow), .green(green),
    .active_way(active_way), .clock(clock), .phase_done(phase_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: phase index 0=all-red,1=green,2=yellow with a duration table,
  // remaining-cycle count, serving way, pending-request bitmask and age inside flash.
  int m_flash, m_phase, m_rem, m_way, m_pend, m_fage;
  int dur[3] = '{TR, TG, TY};

  task automatic model_step(input logic r, input logic e, input logic f, input logic [N-1:0] q);
    int newpend;
    if (r) begin
      m_flash = 0; m_phase = 0; m_rem = TR; m_way = N - 1; m_pend = 0; m_fage = 0;
      return;
    end
    newpend = m_pend | int'(q);
    if (f) begin
      if (m_flash != 0) m_fage++;
      else begin m_flash = 1; m_fage = 0; end
    end else if (m_flash != 0) begin
      m_flash = 0; m_phase = 0; m_rem = TR;
    end else if (e) begin
      if (m_rem == 1) begin
        m_phase = (m_phase + 1) % 3;
        if (m_phase == 1) begin
          m_way = (m_way + 1) % N;
          newpend = newpend & ~(1 << m_way);
        end
        m_rem = dur[m_phase];
      end else if (m_phase == 1 && (newpend & ~(1 << m_way)) != 0 && m_rem > TP) begin
        m_rem = TP;
      end else begin
        m_rem--;
      end
    end
    m_pend = newpend;
  endtask

  task automatic model_check();
    int all, oh, er, ey, eg, ec, ep;
    all = (1 << N) - 1;
    oh  = 1 << m_way;
    er = 0; ey = 0; eg = 0; ec = m_rem;
    if (m_flash != 0) begin
      ey = ((m_fage % (2 * TF)) < TF) ? all : 0;
      ec = 0;
    end else if (m_phase == 0) er = all;
    else begin
      er = all & ~oh;
      if (m_phase == 1) eg = oh; else ey = oh;
    end
    ep = (!rst && !flash_mode && en && m_flash == 0 && m_rem == 1) ? 1 : 0;
    check("rnd_red", red, er);
    check("rnd_yellow", yellow, ey);
    check("rnd_green", green, eg);
    check("rnd_clock", clock, ec);
    check("rnd_way", active_way, m_way);
    check("rnd_phase_done", phase_done, ep);
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic tick(input logic r, input logic e, input logic f, input logic [N-1:0] q);
    @(negedge clk);
    rst = r; en = e; flash_mode = f; pass_request = q;
    @(posedge clk);
    model_step(r, e, f, q);
    #1;
  endtask

  function automatic bit cond(input int sel, input int t);
    case (sel)
      0:       return green == 2'b01 && clock == CW'(t);
      1:       return green == 2'b10 && clock == CW'(t);
      2:       return yellow != 0 && clock == CW'(t);
      default: return green != 0 && clock == CW'(t);
    endcase
  endfunction

  task automatic run_until(input int sel, input int t, input string name);
    bit hit;
    hit = cond(sel, t);
    for (int k = 0; k < 400 && !hit; k++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      hit = cond(sel, t);
    end
    check(name, hit, 1);
  endtask

  typedef struct {
    logic r, e, f;
    logic [N-1:0] q;
    logic [CW-1:0] clk_e;
    logic [N-1:0] red_e, yel_e, grn_e;
    logic [IW-1:0] way_e;
    logic pd_e;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int pulses, greens, w;
    logic [N-1:0] y0;
    logic fl, rr, ee;
    logic [N-1:0] qq;

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'b00, 8'd2,  2'b11, 2'b00, 2'b00, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'b00, 8'd1,  2'b11, 2'b00, 2'b00, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 2'b00, 8'd60, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 2'b00, 8'd60, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 2'b10, 8'd10, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'b00, 8'd9,  2'b10, 2'b00, 2'b01, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'b00, 8'd0,  2'b00, 2'b11, 2'b00, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 2'b00, 8'd0,  2'b00, 2'b11, 2'b00, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 2'b00, 8'd2,  2'b11, 2'b00, 2'b00, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'b00, 8'd1,  2'b11, 2'b00, 2'b00, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2'b00, 8'd60, 2'b01, 2'b00, 2'b10, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 2'b00, 8'd59, 2'b01, 2'b00, 2'b10, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 2'b00, 8'd2,  2'b11, 2'b00, 2'b00, 1'b1, 1'b0};

    for (int i = 0; i < 13; i++) begin
      tick(vecs[i].r, vecs[i].e, vecs[i].f, vecs[i].q);
      check($sformatf("vec%0d_clock", i), clock, vecs[i].clk_e);
      check($sformatf("vec%0d_red", i), red, vecs[i].red_e);
      check($sformatf("vec%0d_yellow", i), yellow, vecs[i].yel_e);
      check($sformatf("vec%0d_green", i), green, vecs[i].grn_e);
      check($sformatf("vec%0d_way", i), active_way, vecs[i].way_e);
      check($sformatf("vec%0d_pd", i), phase_done, vecs[i].pd_e);
    end

    // Free-run period: 134 cycles, six phase_done pulses, 120 green cycles.
    tick(1'b1, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, '0);
    tick(1'b0, 1'b1, 1'b0, '0);
    check("start_green", green, 2'b01);
    check("start_clock", clock, 60);
    pulses = 0; greens = 0;
    for (int i = 1; i <= 134; i++) begin
      tick(1'b0, 1'b1, 1'b0, '0);
      if (phase_done) pulses++;
      if (green != 0) greens++;
      if (i == 67) begin
        check("half_green", green, 2'b10);
        check("half_clock", clock, 60);
      end
    end
    check("period_pulses", pulses, 6);
    check("period_greens", greens, 120);
    check("period_green", green, 2'b01);
    check("period_clock", clock, 60);

    // Shortening from clock=40, then clear on way1 green, then no effect at clock=8.
    run_until(0, 40, "wait_c40");
    tick(1'b0, 1'b1, 1'b0, 2'b10);
    check("short_clock", clock, 10);
    for (int i = 0; i < 9; i++) tick(1'b0, 1'b1, 1'b0, '0);
    check("short_last_green", green, 2'b01);
    check("short_last_clock", clock, 1);
    tick(1'b0, 1'b1, 1'b0, '0);
    check("short_yellow", yellow, 2'b01);
    check("short_yellow_clock", clock, TY);
    run_until(1, 60, "wait_w1_green");
    for (int i = 0; i < 30; i++) tick(1'b0, 1'b1, 1'b0, '0);
    check("cleared_clock", clock, 30);
    check("cleared_green", green, 2'b10);
    run_until(0, 8, "wait_c8");
    tick(1'b0, 1'b1, 1'b0, 2'b10);
    check("late_req_clock", clock, 7);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, '0);
    check("late_req_last", clock, 1);
    tick(1'b0, 1'b1, 1'b0, '0);
    check("late_req_yellow", yellow, 2'b01);

    // Hold during yellow at clock=3.
    run_until(2, 3, "wait_y3");
    y0 = yellow;
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b0, 1'b0, '0);
      check("hold_clock", clock, 3);
      check("hold_yellow", yellow, y0);
      check("hold_pd", phase_done, 0);
    end
    tick(1'b0, 1'b1, 1'b0, '0);
    check("resume_c2", clock, 2);
    tick(1'b0, 1'b1, 1'b0, '0);
    check("resume_c1", clock, 1);
    check("resume_y", yellow, y0);
    tick(1'b0, 1'b1, 1'b0, '0);
    check("resume_allred", red, 2'b11);
    check("resume_clr", clock, TR);

    // Flash mode mid-green.
    run_until(3, 30, "wait_g30");
    w = int'(active_way);
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b1, 1'b1, '0);
      check("flash_yellow", yellow, ((i % 8) < 4) ? 2'b11 : 2'b00);
      check("flash_red", red, 0);
      check("flash_green", green, 0);
      check("flash_clock", clock, 0);
      check("flash_pd", phase_done, 0);
    end
    tick(1'b0, 1'b1, 1'b0, '0);
    check("unflash_red", red, 2'b11);
    check("unflash_clock", clock, TR);
    check("unflash_way", active_way, w);
    tick(1'b0, 1'b1, 1'b0, '0);
    check("unflash_c1", clock, 1);
    tick(1'b0, 1'b1, 1'b0, '0);
    check("unflash_green", green, 1 << ((w + 1) % N));
    check("unflash_next_way", active_way, (w + 1) % N);

    // Reset mid-green with requests held.
    run_until(3, 20, "wait_g20");
    tick(1'b1, 1'b1, 1'b0, 2'b11);
    check("rst_red", red, 2'b11);
    check("rst_yellow", yellow, 0);
    check("rst_green", green, 0);
    check("rst_clock", clock, TR);
    check("rst_way", active_way, N - 1);
    check("rst_pd", phase_done, 0);
    tick(1'b0, 1'b1, 1'b0, 2'b11);
    check("rst_c1", clock, 1);
    tick(1'b0, 1'b1, 1'b0, 2'b11);
    check("rst_green_w0", green, 2'b01);
    check("rst_green_clock", clock, TG);
    tick(1'b0, 1'b1, 1'b0, 2'b11);
    check("rst_short", clock, TP);

    // Randomized run against the reference model.
    fl = 1'b0;
    tick(1'b1, 1'b1, 1'b0, '0);
    model_check();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) fl = !fl;
      rr = ($urandom_range(0, 799) == 0);
      ee = ($urandom_range(0, 9) != 0);
      for (int b = 0; b < N; b++) qq[b] = ($urandom_range(0, 29) == 0);
      tick(rr, ee, fl, qq);
      model_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
